// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of the read, issue and writeback signals of the
// scoreboarded register file.
//   r_addr  : NUM_READ packed read addresses, port p at [p*ADDR_SIZE +: ADDR_SIZE]
//   r_data  : NUM_READ packed read data, port p at [p*WORD_SIZE +: WORD_SIZE]
//   r_busy  : per read port, addressed register still awaits a result
//   i_valid, i_addr        : issue, marks i_addr as pending
//   d_we, d_addr, d_data   : writeback write
//   d_pend  : qualifies d_we, the write retires a pending result
//   err     : sticky scoreboard protocol error
// master = decode/writeback side, slave = register file.
interface regfile_sb_if #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32,
  parameter int NUM_READ  = 2
);
  logic [NUM_READ*ADDR_SIZE-1:0] r_addr;
  logic [NUM_READ*WORD_SIZE-1:0] r_data;
  logic [NUM_READ-1:0]           r_busy;
  logic                          i_valid;
  logic [ADDR_SIZE-1:0]          i_addr;
  logic                          d_we;
  logic [ADDR_SIZE-1:0]          d_addr;
  logic [WORD_SIZE-1:0]          d_data;
  logic                          d_pend;
  logic                          err;

  modport master (
    output r_addr, i_valid, i_addr, d_we, d_addr, d_data, d_pend,
    input  r_data, r_busy, err
  );

  modport slave (
    input  r_addr, i_valid, i_addr, d_we, d_addr, d_data, d_pend,
    output r_data, r_busy, err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with hardwired-zero register 0,
// optional write-to-read bypass and a per-register pending-write scoreboard
// so decode can stall on outstanding multi-cycle results.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset of data, scoreboard and err
//   bus  : regfile_sb_if.slave (reads, issue, writeback, err)
module regfile_sb #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32,
  parameter int NUM_READ  = 2,
  parameter int BYPASS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_SIZE;

  // regs[0] is never written and stays at its reset value of zero.
  logic [WORD_SIZE-1:0] regs [NREG];
  logic [NREG-1:0]      pend;
  logic                 err_q;

  logic set_v;
  logic clr_v;
  logic err_set;

  always_comb begin
    set_v   = bus.i_valid && (bus.i_addr != '0);
    clr_v   = bus.d_we && bus.d_pend && (bus.d_addr != '0);
    // Re-issue is legal only when the same register retires in this cycle;
    // retiring something that was never issued is always an error.
    err_set = (set_v && pend[bus.i_addr] && !(clr_v && (bus.d_addr == bus.i_addr)))
           || (clr_v && !pend[bus.d_addr]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      pend  <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.d_we && (bus.d_addr != '0)) regs[bus.d_addr] <= bus.d_data;
      if (clr_v) pend[bus.d_addr] <= 1'b0;
      // Placed after the clear so a same-register issue wins.
      if (set_v) pend[bus.i_addr] <= 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_SIZE-1:0] ra;
    logic                 hit;

    assign ra  = bus.r_addr[p*ADDR_SIZE +: ADDR_SIZE];
    assign hit = (BYPASS != 0) && bus.d_we && (bus.d_addr == ra);

    assign bus.r_data[p*WORD_SIZE +: WORD_SIZE] =
      (ra == '0) ? '0 : (hit ? bus.d_data : regs[ra]);
    // pend[0] is never set, so address 0 never reports busy.
    assign bus.r_busy[p] = pend[ra] && !(hit && bus.d_pend);
  end

  assign bus.err = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int AS   = 5;
  localparam int WS   = 32;
  localparam int NR   = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .NUM_READ(NR)) bus ();

  regfile_sb #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .NUM_READ(NR), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register contents and pending flags.
  logic [31:0] m_regs [NREG];
  bit          m_pend [NREG];
  bit          m_err;

  typedef struct {
    logic        rst_v;
    logic        iv;
    logic [4:0]  ia;
    logic        we;
    logic        dp;
    logic [4:0]  da;
    logic [31:0] dd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        b0;
    logic        b1;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic iv, input logic [4:0] ia,
                       input logic we, input logic dp, input logic [4:0] da,
                       input logic [31:0] dd, input logic [4:0] ra0, input logic [4:0] ra1);
    rst         = rv;
    bus.i_valid = iv;
    bus.i_addr  = ia;
    bus.d_we    = we;
    bus.d_pend  = dp;
    bus.d_addr  = da;
    bus.d_data  = dd;
    bus.r_addr  = {ra1, ra0};
  endtask

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.d_we && bus.d_addr == a) return bus.d_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(bus.d_we && bus.d_pend && bus.d_addr == a);
  endfunction

  // Applies the architectural effect of the current inputs at a clock edge.
  task automatic model_edge();
    bit s, c;
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        m_regs[k] = 32'h0;
        m_pend[k] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      s = bus.i_valid && bus.i_addr != 0;
      c = bus.d_we && bus.d_pend && bus.d_addr != 0;
      if (c && !m_pend[bus.d_addr]) m_err = 1'b1;
      if (s && m_pend[bus.i_addr] && !(c && bus.d_addr == bus.i_addr)) m_err = 1'b1;
      if (bus.d_we && bus.d_addr != 0) m_regs[bus.d_addr] = bus.d_data;
      if (c) m_pend[bus.d_addr] = 1'b0;
      if (s) m_pend[bus.i_addr] = 1'b1;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic vec_t mk(input logic rv, input logic iv, input logic [4:0] ia,
                              input logic we, input logic dp, input logic [4:0] da,
                              input logic [31:0] dd, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic b0, input logic b1, input logic e_err);
    vec_t v;
    v.rst_v = rv; v.iv = iv; v.ia = ia; v.we = we; v.dp = dp; v.da = da; v.dd = dd;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.b0 = b0; v.b1 = b1; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    logic [4:0]  ia, da, ra0, ra1;
    logic        iv, we, dp, rv;
    logic [31:0] dd;

    // Expectations are the combinational outputs seen with this row's inputs,
    // before the row's clock edge.
    //          rst iv ia  we dp da  dd            ra0 ra1 e0            e1            b0 b1 err
    vecs.push_back(mk(1, 0, 0,  1, 0, 3,  32'hDEADBEEF, 0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        3,  3,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 0, 0,  32'h12345678, 0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 0, 5,  32'h11,       0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 0, 5,  32'h22,       5,  5,  32'h22,       32'h22,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        5,  5,  32'h22,       32'h22,       0, 0, 0));
    vecs.push_back(mk(0, 1, 7,  0, 0, 0,  32'h0,        7,  7,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        7,  5,  32'h0,        32'h22,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 7,  32'hA5,       7,  7,  32'hA5,       32'hA5,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        7,  7,  32'hA5,       32'hA5,       0, 0, 0));
    vecs.push_back(mk(0, 1, 9,  0, 0, 0,  32'h0,        9,  9,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 9,  1, 1, 9,  32'h99,       9,  0,  32'h99,       32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        9,  9,  32'h99,       32'h99,       1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 9,  32'h100,      9,  9,  32'h100,      32'h100,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        9,  9,  32'h100,      32'h100,      0, 0, 0));
    vecs.push_back(mk(0, 1, 4,  0, 0, 0,  32'h0,        4,  4,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 4,  0, 0, 0,  32'h0,        4,  4,  32'h0,        32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        4,  4,  32'h0,        32'h0,        1, 1, 1));
    vecs.push_back(mk(0, 0, 0,  1, 0, 10, 32'h55,       10, 4,  32'h55,       32'h0,        0, 1, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        4,  10, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 6,  32'h66,       6,  6,  32'h66,       32'h66,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  32'h0,        6,  6,  32'h66,       32'h66,       0, 0, 1));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    finish_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_v, vecs[i].iv, vecs[i].ia, vecs[i].we, vecs[i].dp,
            vecs[i].da, vecs[i].dd, vecs[i].ra0, vecs[i].ra1);
      @(negedge clk);
      chk($sformatf("vec%0d r_data0", i), bus.r_data[31:0],  vecs[i].e0);
      chk($sformatf("vec%0d r_data1", i), bus.r_data[63:32], vecs[i].e1);
      chk($sformatf("vec%0d r_busy",  i), {30'h0, bus.r_busy}, {30'h0, vecs[i].b1, vecs[i].b0});
      chk($sformatf("vec%0d err",     i), {31'h0, bus.err},  {31'h0, vecs[i].e_err});
      finish_cycle();
    end

    // Randomised traffic against the model, with small address pool for collisions.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    finish_cycle();
    for (int n = 0; n < 600; n++) begin
      rv = ($urandom_range(0, 59) == 0);
      ia = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      iv = ($urandom_range(0, 9) < 4);
      if (iv && m_pend[ia] && $urandom_range(0, 7) != 0) iv = 1'b0;
      da = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      we = ($urandom_range(0, 1) == 1);
      dp = ($urandom_range(0, 1) == 1);
      if (dp && !m_pend[da] && $urandom_range(0, 7) != 0) dp = 1'b0;
      if (we && !dp && m_pend[da] && $urandom_range(0, 1) == 0) dp = 1'b1;
      dd = $urandom;
      ra0 = ($urandom_range(0, 2) == 0) ? da : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom_range(0, 7));
      drive(rv, iv, ia, we, dp, da, dd, ra0, ra1);
      @(negedge clk);
      chk("rnd r_data0", bus.r_data[31:0],  m_rdata(ra0));
      chk("rnd r_data1", bus.r_data[63:32], m_rdata(ra1));
      chk("rnd r_busy",  {30'h0, bus.r_busy}, {30'h0, m_busy(ra1), m_busy(ra0)});
      chk("rnd err",     {31'h0, bus.err},  {31'h0, m_err});
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
